// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480@60 timing for the VGA receive-timing block.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_TOTAL  = 800;

    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_TOTAL  = 525;

    localparam int DEF_CNT_W    = 10;

endpackage

// File: rtl/vga_rx_sync_edge.sv
// Two-flop sampler for one received sync line plus a leading-edge detector
// (edge = transition into the POL level, seen on the second flop).
module vga_rx_sync_edge #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic lead
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else if (pix_en) begin
            s1 <= sync_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 is the previous pix_en sample of s2, so the edge is reported exactly once.
    assign lead = pix_en && (s2 == POL) && (s3 != POL);

endmodule

// File: rtl/vga_rx_timing.sv
// VGA receive timing: locks to hsync/vsync, regenerates x/y/valid, measures line and
// frame length and flags lock loss. Define VGA_RX_CHECKSUM_EN to add a per-frame pixel sum.
module vga_rx_timing
    import vga_rx_pkg::*;
#(
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [2:0]       rgb_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             valid,
    output logic [2:0]       pixel,
    output logic             newline,
    output logic             newframe,
    output logic             locked,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             timing_err
`ifdef VGA_RX_CHECKSUM_EN
    ,
    output logic [15:0]      frame_sum,
    output logic             sum_valid
`endif
);

    localparam int M_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_OFF   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_OFF   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [M_W-1:0]   M_LOCK  = M_W'(LOCK_FRAMES);

    // Bit 0 carries hsync, bit 1 vsync.
    logic [1:0] sync_raw;
    logic [1:0] sync_lead;
    logic       h_lead;
    logic       v_lead;

    assign sync_raw = {vsync_in, hsync_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        vga_rx_sync_edge #(
            .POL (SYNC_POL)
        ) u_edge (
            .clk     (clk),
            .rst     (rst),
            .pix_en  (pix_en),
            .sync_in (sync_raw[gi]),
            .lead    (sync_lead[gi])
        );
    end

    assign h_lead = sync_lead[0];
    assign v_lead = sync_lead[1];

    logic [2:0]       rgb1;
    logic [2:0]       rgb2;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] hcnt_next;
    logic [CNT_W-1:0] vcnt_next;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] frame_len;
    logic             h_timeout;
    logic             x_in;
    logic             y_in;

    rx_state_t        state;
    logic [CNT_W-1:0] ref_h;
    logic [CNT_W-1:0] ref_v;
    logic             have_ref_h;
    logic [M_W-1:0]   match_cnt;
    logic [M_W-1:0]   match_next;
    logic             line_bad;
    logic             frame_bad;

    always_comb begin
        // A saturated counter reports all-ones rather than wrapping to zero.
        line_len  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 1'b1;
        hcnt_next = hcnt;
        if (pix_en) begin
            if (h_lead) begin
                hcnt_next = '0;
            end else if (hcnt != CNT_MAX) begin
                hcnt_next = hcnt + 1'b1;
            end
        end
        // The line is counted before the frame closes when both edges coincide.
        frame_len = (h_lead && vcnt != CNT_MAX) ? vcnt + 1'b1 : vcnt;
        vcnt_next = v_lead ? '0 : frame_len;
        h_timeout = pix_en && !h_lead && (hcnt == CNT_MAX - 1'b1);
        x_in      = (hcnt_next >= H_OFF) && ((hcnt_next - H_OFF) < H_ACT);
        y_in      = (vcnt_next >= V_OFF) && ((vcnt_next - V_OFF) < V_ACT);
        line_bad  = h_lead && (line_len != ref_h);
        frame_bad = v_lead && (frame_len != ref_v);
        match_next = (frame_len == ref_v) ? match_cnt + 1'b1 : M_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb1     <= '0;
            rgb2     <= '0;
            pixel    <= '0;
            hcnt     <= '0;
            vcnt     <= '0;
            x        <= '0;
            y        <= '0;
            valid    <= 1'b0;
            newline  <= 1'b0;
            newframe <= 1'b0;
            h_total  <= '0;
            v_total  <= '0;
        end else begin
            newline  <= h_lead;
            newframe <= v_lead;
            if (pix_en) begin
                rgb1  <= rgb_in;
                rgb2  <= rgb1;
                pixel <= rgb2;
                hcnt  <= hcnt_next;
                vcnt  <= vcnt_next;
                if (x_in && y_in) begin
                    x <= hcnt_next - H_OFF;
                    y <= vcnt_next - V_OFF;
                end
                valid <= locked && x_in && y_in;
            end
            if (h_lead) begin
                h_total <= line_len;
            end
            if (v_lead) begin
                v_total <= frame_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            ref_h      <= '0;
            ref_v      <= '0;
            have_ref_h <= 1'b0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_lead) begin
                        state      <= MEASURE;
                        match_cnt  <= '0;
                        have_ref_h <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (have_ref_h && line_bad) begin
                        state <= SEARCH;
                    end else begin
                        if (h_lead && !have_ref_h) begin
                            ref_h      <= line_len;
                            have_ref_h <= 1'b1;
                        end
                        if (v_lead) begin
                            match_cnt <= match_next;
                            if (frame_len != ref_v) begin
                                ref_v <= frame_len;
                            end
                            if (match_next == M_LOCK) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad || h_timeout) begin
                        state      <= SEARCH;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (v_lead) begin
                sum_acc <= '0;
                if (locked) begin
                    frame_sum <= sum_acc;
                    sum_valid <= 1'b1;
                end
            end else if (pix_en && locked && x_in && y_in) begin
                // rgb2 is the value loaded into pixel alongside this valid.
                sum_acc <= sum_acc + {13'b0, rgb2};
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_rx_timing.sv
// Scoreboard bench for vga_rx_timing using a reduced 28x15 raster so frames stay short.
module tb_vga_rx_timing;

    localparam int HS = 4;
    localparam int HB = 4;
    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HT = HS + HB + HA + HF;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VT = VS + VB + VA + VF;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_en = 1'b0;
    logic          hsync_in = 1'b1;
    logic          vsync_in = 1'b1;
    logic [2:0]    rgb_in = 3'b000;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          valid;
    logic [2:0]    pixel;
    logic          newline;
    logic          newframe;
    logic          locked;
    logic [CW-1:0] h_total;
    logic [CW-1:0] v_total;
    logic          timing_err;
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0]   frame_sum;
    logic          sum_valid;
`endif

    always #5 clk = ~clk;

    vga_rx_timing #(
        .H_SYNC      (HS),
        .H_BP        (HB),
        .H_ACTIVE    (HA),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .V_ACTIVE    (VA),
        .SYNC_POL    (1'b0),
        .LOCK_FRAMES (2),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rgb_in     (rgb_in),
        .x          (x),
        .y          (y),
        .valid      (valid),
        .pixel      (pixel),
        .newline    (newline),
        .newframe   (newframe),
        .locked     (locked),
        .h_total    (h_total),
        .v_total    (v_total),
        .timing_err (timing_err)
`ifdef VGA_RX_CHECKSUM_EN
        ,
        .frame_sum  (frame_sum),
        .sum_valid  (sum_valid)
`endif
    );

    typedef struct {
        int         tick;
        int         ex;
        int         ey;
        logic [2:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ptick = 0;
    int   vcount = 0;
    int   err_pulses = 0;
    int   err_line = -1;
    int   cur_line = 0;
    int   sum_pulses = 0;
    bit   slow = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] color(input int mode, input int ax, input int ay);
        if (mode == 1) return 3'b111;
        if (mode == 2) return (ax == 0 && ay == 0) ? 3'b101 : 3'b000;
        return 3'(ax + ay);
    endfunction

    // Drives one pixel; n is the pix_en tick number at which the DUT samples it.
    task automatic tick(input logic hs, input logic vs, input logic [2:0] c, output int n);
        @(negedge clk);
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = c;
        pix_en   = 1'b1;
        n        = ptick + 1;
        if (slow) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic idle(input int cnt);
        int n;
        for (int i = 0; i < cnt; i++) tick(1'b1, 1'b1, 3'b000, n);
    endtask

    // Sends nlines of a frame; long_line gets one extra pixel and, if valid was
    // expected, ends the expectation after that line.
    task automatic send_frame(input int nlines, input int long_line, input bit exp_valid,
                              input int mode);
        int n;
        for (int l = 0; l < nlines; l++) begin
            cur_line = l;
            for (int h = 0; h < HT + ((l == long_line) ? 1 : 0); h++) begin
                int ax;
                int ay;
                bit act;
                logic [2:0] c;
                ax  = h - HS - HB;
                ay  = l - VS - VB;
                act = (ax >= 0) && (ax < HA) && (ay >= 0) && (ay < VA);
                c   = act ? color(mode, ax, ay) : 3'b000;
                tick(h >= HS, l >= VS, c, n);
                if (act && exp_valid && (long_line < 0 || l <= long_line))
                    sb.push_back('{n + 2, ax, ay, c});
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_pixel"}, 32'(pixel), 0);
        chk({tag, "_newline"}, 32'(newline), 0);
        chk({tag, "_newframe"}, 32'(newframe), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_h_total"}, 32'(h_total), 0);
        chk({tag, "_v_total"}, 32'(v_total), 0);
        chk({tag, "_timing_err"}, 32'(timing_err), 0);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                #1;
                if (timing_err === 1'b1) begin
                    err_pulses++;
                    err_line = cur_line;
                end
`ifdef VGA_RX_CHECKSUM_EN
                if (sum_valid === 1'b1) sum_pulses++;
`endif
                if (pix_en && rst) begin
                    ptick++;
                    if (valid === 1'b1) begin
                        vcount++;
                        if (sb.size() == 0) begin
                            chk("valid_spurious", 32'(valid), 0);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("x", 32'(x), 32'(e.ex));
                            chk("y", 32'(y), 32'(e.ey));
                            chk("pixel", 32'(pixel), 32'(e.rgb));
                            chk("latency_tick", 32'(ptick), 32'(e.tick));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Lock acquisition: first vsync edge enters MEASURE, lock at the third.
        send_frame(VT, -1, 1'b0, 0);
        chk("locked_f1", 32'(locked), 0);
        send_frame(VT, -1, 1'b0, 0);
        chk("locked_f2", 32'(locked), 0);
        send_frame(VT, -1, 1'b1, 1);
        chk("locked_f3", 32'(locked), 1);
        chk("h_total_f3", 32'(h_total), HT);
        chk("v_total_f3", 32'(v_total), VT);
        chk("valid_count_f3", 32'(vcount), HA * VA);
        chk("sb_empty_f3", 32'(sb.size()), 0);
        vcount = 0;

        // Single marked pixel at (0,0).
        send_frame(VT, -1, 1'b1, 2);
        chk("valid_count_f4", 32'(vcount), HA * VA);
        chk("sb_empty_f4", 32'(sb.size()), 0);
`ifdef VGA_RX_CHECKSUM_EN
        chk("frame_sum_f3", 32'(frame_sum), (HA * VA * 7) % 65536);
        chk("sum_pulses_f4", 32'(sum_pulses), 1);
`endif
        vcount = 0;

        // One 29-pixel line while locked: error at the start of line 7.
        send_frame(VT, 6, 1'b1, 0);
        chk("err_pulses_long", 32'(err_pulses), 1);
        chk("err_line_long", 32'(err_line), 7);
        chk("locked_after_long", 32'(locked), 0);
        chk("valid_count_f5", 32'(vcount), HA * (6 - VS - VB + 1));
        chk("sb_empty_f5", 32'(sb.size()), 0);
        vcount = 0;

        // Relock with pix_en every other clock.
        slow = 1'b1;
        send_frame(VT, -1, 1'b0, 0);
        send_frame(VT, -1, 1'b0, 0);
        chk("locked_f7", 32'(locked), 0);
        send_frame(VT, -1, 1'b1, 0);
        chk("locked_f8", 32'(locked), 1);
        chk("h_total_f8", 32'(h_total), HT);
        chk("v_total_f8", 32'(v_total), VT);
        chk("err_pulses_f8", 32'(err_pulses), 1);
        chk("valid_count_f8", 32'(vcount), HA * VA);
        chk("sb_empty_f8", 32'(sb.size()), 0);
        vcount = 0;
        slow = 1'b0;

        // Asynchronous reset in the middle of a locked frame.
        send_frame(VS + VB + 3, -1, 1'b1, 0);
        chk("locked_pre_rst", 32'(locked), 1);
        chk("valid_count_pre_rst", 32'(vcount), HA * 3);
        @(negedge clk);
        #2;
        rst      = 1'b0;
        pix_en   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        idle(5);
        send_frame(VT, -1, 1'b0, 0);
        send_frame(VT, -1, 1'b0, 0);
        chk("locked_relock_f2", 32'(locked), 0);
        send_frame(VT, -1, 1'b1, 0);
        chk("locked_relock_f3", 32'(locked), 1);
        chk("valid_count_relock", 32'(vcount), HA * VA);
        chk("sb_empty_relock", 32'(sb.size()), 0);

        // hsync stuck inactive: timeout while locked, h counter saturates.
        send_frame(VS + VB, -1, 1'b0, 0);
        idle(1100);
        chk("err_pulses_timeout", 32'(err_pulses), 2);
        chk("locked_timeout", 32'(locked), 0);
        send_frame(1, -1, 1'b0, 0);
        chk("h_total_saturated", 32'(h_total), (1 << CW) - 1);
        idle(10);
        chk("sb_empty_final", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
